// File: rtl/out_queue.sv
// Display output queue: shows each pushed {sel,val1,val2} entry for HOLD_CYCLES cycles in push order.
// Latency 1 cycle from push to display when nothing is queued; pushes while full are dropped and flagged.

module oq_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_dat,
  output logic [W-1:0]               o_dat,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

module out_queue #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   outdisplay,
  input  logic [15:0]            outval1,
  input  logic [15:0]            outval2,
  input  logic [2:0]             outsel,
  input  logic                   clr_ovf,
  output logic [15:0]            disp_val1,
  output logic [15:0]            disp_val2,
  output logic [2:0]             disp_sel,
  output logic                   disp_strobe,
  output logic                   disp_valid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_PARK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hold;
  logic [34:0]   r_disp;
  logic          r_strobe;
  logic          r_valid;
  logic          r_ovf;

  logic [34:0]   w_in_dat;
  logic [34:0]   w_head_dat;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_expire;
  logic          w_bypass;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_drop;

  assign w_in_dat = {outsel, outval1, outval2};
  assign w_full   = (w_count == CW'(DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_expire = (r_state == ST_SHOW) && (r_hold == HW'(HOLD_CYCLES - 1));

  // Nothing waiting and nothing (still) being held: the push goes straight to the display.
  assign w_bypass   = outdisplay && ((r_state != ST_SHOW) || (w_expire && w_empty));
  assign w_pop      = w_expire && !w_empty;
  assign w_push_req = outdisplay && !w_bypass;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  oq_fifo #(.W(35), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_in_dat),
    .o_dat   (w_head_dat),
    .o_count (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_bypass) w_state_nxt = ST_SHOW;
      ST_SHOW: if (w_expire && w_empty && !w_bypass) w_state_nxt = ST_PARK;
      ST_PARK: if (w_bypass) w_state_nxt = ST_SHOW;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold   <= '0;
      r_disp   <= '0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_strobe <= w_bypass || w_pop;
      if (w_bypass || w_pop)     r_hold <= '0;
      else if (r_state == ST_SHOW) r_hold <= r_hold + HW'(1);
      if (w_bypass) begin
        r_disp  <= w_in_dat;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_disp  <= w_head_dat;
        r_valid <= 1'b1;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign disp_sel    = r_disp[34:32];
  assign disp_val1   = r_disp[31:16];
  assign disp_val2   = r_disp[15:0];
  assign disp_strobe = r_strobe;
  assign disp_valid  = r_valid;
  assign busy        = (r_state == ST_SHOW);
  assign count       = w_count;
  assign full        = w_full;
  assign overflow    = r_ovf;
endmodule
